// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI burst register bank.
package spi_reg_pkg;

   // Transaction phase of the SPI frame decoder
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2
   } state_t;

   // Command word layout for the default 8-bit word
   localparam int unsigned REG_WIDTH_DEF = 8;
   localparam int unsigned CMD_RW_BIT    = REG_WIDTH_DEF - 1;

   // Total addressable registers (RW region followed by RO region)
   function automatic int unsigned total_regs(input int unsigned num_rw,
                                              input int unsigned num_ro);
      return num_rw + num_ro;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with single-cycle rise/fall pulses on the synced level.
module spi_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_rst_val,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise_c,
   output logic o_fall_c
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Metastability flops plus one history flop for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= i_rst_val;
         r_sync <= i_rst_val;
         r_prev <= i_rst_val;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync   = r_sync;
   assign o_rise_c = r_sync & ~r_prev;
   assign o_fall_c = ~r_sync & r_prev;

endmodule

// File: rtl/spi_reg_bank_burst.sv
// SPI peripheral register bank: RW + RO regions, all SPI modes, burst access with wrap.
module spi_reg_bank_burst
   import spi_reg_pkg::*;
#(
   parameter int unsigned REG_WIDTH  = 8,
   parameter int unsigned NUM_RW     = 8,
   parameter int unsigned NUM_RO     = 8,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cpol_i,
   input  logic                          cpha_i,
   input  logic                          spi_cs_n_i,
   input  logic                          spi_clk_i,
   input  logic                          spi_mosi_i,
   output logic                          spi_miso_o,
   output logic                          spi_miso_oe_o,
   input  logic [NUM_RO*REG_WIDTH-1:0]   ro_regs_i,
   output logic [NUM_RW*REG_WIDTH-1:0]   rw_regs_o,
   output logic                          wr_strobe_o,
   output logic [ADDR_WIDTH-1:0]         wr_addr_o,
   output logic                          busy_o
);

   localparam int unsigned TOTAL  = total_regs(NUM_RW, NUM_RO);
   localparam int unsigned BCW    = (REG_WIDTH > 2) ? $clog2(REG_WIDTH) : 1;
   localparam int unsigned RW_BIT = REG_WIDTH - 1;

   state_t                       r_state;
   state_t                       w_state_nxt;

   logic                         w_cs_sync;
   logic                         w_cs_rise;
   logic                         w_cs_fall;
   logic                         w_sclk_sync;
   logic                         w_sclk_rise;
   logic                         w_sclk_fall;
   logic                         w_unused;
   logic                         r_mosi_meta;
   logic                         r_mosi_sync;

   logic                         r_cpol;
   logic                         r_cpha;
   logic [BCW-1:0]               r_bit_cnt;
   logic [REG_WIDTH-1:0]         r_rx;
   logic [REG_WIDTH-1:0]         r_tx;
   logic [ADDR_WIDTH-1:0]        r_addr;
   logic                         r_is_write;
   logic                         r_load;
   logic                         r_miso;
   logic                         r_busy;
   logic                         r_wr_strobe;
   logic [ADDR_WIDTH-1:0]        r_wr_addr;
   logic [NUM_RW*REG_WIDTH-1:0]  r_rw_flat;

   logic                         w_lead;
   logic                         w_trail;
   logic                         w_sample;
   logic                         w_shift;
   logic                         w_last_bit;
   logic [REG_WIDTH-1:0]         w_rx_word;
   logic [REG_WIDTH-1:0]         w_rd_word;
   logic [ADDR_WIDTH-1:0]        w_addr_nxt;
   logic                         w_wr_en;
   logic                         w_active;
   logic                         w_frame_start;
   logic                         w_cmd_done;
   logic                         w_word_done;

   spi_sync_edge u_sync_cs (
      .clk      (clk),
      .rst      (rst),
      .i_rst_val(1'b1),
      .i_async  (spi_cs_n_i),
      .o_sync   (w_cs_sync),
      .o_rise_c (w_cs_rise),
      .o_fall_c (w_cs_fall)
   );

   spi_sync_edge u_sync_sclk (
      .clk      (clk),
      .rst      (rst),
      .i_rst_val(cpol_i),
      .i_async  (spi_clk_i),
      .o_sync   (w_sclk_sync),
      .o_rise_c (w_sclk_rise),
      .o_fall_c (w_sclk_fall)
   );

   // Only the cs_n level and sclk edges drive the decoder
   assign w_unused = ^{w_sclk_sync, w_cs_rise};

   // MOSI synchroniser, aligned in latency with the sclk edge pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mosi_meta <= 1'b0;
         r_mosi_sync <= 1'b0;
      end else begin
         r_mosi_meta <= spi_mosi_i;
         r_mosi_sync <= r_mosi_meta;
      end
   end

   // Edge roles from the mode latched at frame start
   assign w_lead     = r_cpol ? w_sclk_fall : w_sclk_rise;
   assign w_trail    = r_cpol ? w_sclk_rise : w_sclk_fall;
   assign w_sample   = r_cpha ? w_trail : w_lead;
   assign w_shift    = r_cpha ? w_lead : w_trail;
   assign w_rx_word  = {r_rx[REG_WIDTH-2:0], r_mosi_sync};
   assign w_last_bit = w_sample && (r_bit_cnt == BCW'(REG_WIDTH - 1));
   assign w_addr_nxt = (32'(r_addr) == TOTAL - 1) ? '0 : r_addr + ADDR_WIDTH'(1);
   assign w_wr_en    = w_word_done && r_is_write && (32'(r_addr) < NUM_RW);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next-state: cs_n high always closes the frame
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_cs_fall) w_state_nxt = CMD;
         CMD:     if (w_cs_sync) w_state_nxt = IDLE;
                  else if (w_last_bit) w_state_nxt = DATA;
         DATA:    if (w_cs_sync) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM outputs: per-phase control strobes for the datapath
   always_comb begin
      w_active      = 1'b0;
      w_frame_start = 1'b0;
      w_cmd_done    = 1'b0;
      w_word_done   = 1'b0;
      case (r_state)
         IDLE:    w_frame_start = w_cs_fall;
         CMD: begin
            w_active   = 1'b1;
            w_cmd_done = w_last_bit;
         end
         DATA: begin
            w_active    = 1'b1;
            w_word_done = w_last_bit;
         end
         default: ;
      endcase
   end

   // Read mux over RW array, RO inputs, and zero for unmapped addresses
   always_comb begin
      w_rd_word = '0;
      for (int unsigned k = 0; k < NUM_RW; k++) begin
         if (32'(r_addr) == k) w_rd_word = r_rw_flat[k*REG_WIDTH +: REG_WIDTH];
      end
      for (int unsigned k = 0; k < NUM_RO; k++) begin
         if (32'(r_addr) == NUM_RW + k) w_rd_word = ro_regs_i[k*REG_WIDTH +: REG_WIDTH];
      end
   end

   // RW register array: commits on the last sample of a write data word
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rw_flat <= '0;
      end else if (w_wr_en) begin
         for (int unsigned k = 0; k < NUM_RW; k++) begin
            if (32'(r_addr) == k) r_rw_flat[k*REG_WIDTH +: REG_WIDTH] <= w_rx_word;
         end
      end
   end

   // Frame datapath: bit counter, shift registers, address, MISO and status
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cpol      <= 1'b0;
         r_cpha      <= 1'b0;
         r_bit_cnt   <= '0;
         r_rx        <= '0;
         r_tx        <= '0;
         r_addr      <= '0;
         r_is_write  <= 1'b0;
         r_load      <= 1'b0;
         r_miso      <= 1'b0;
         r_busy      <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
      end else begin
         r_wr_strobe <= 1'b0;
         r_busy      <= (w_state_nxt != IDLE);

         if (w_frame_start) begin
            r_cpol    <= cpol_i;
            r_cpha    <= cpha_i;
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
         end

         if (w_active && w_sample) begin
            r_rx      <= w_rx_word;
            r_bit_cnt <= (r_bit_cnt == BCW'(REG_WIDTH - 1)) ? '0 : r_bit_cnt + BCW'(1);
         end

         if (w_cmd_done) begin
            r_addr     <= w_rx_word[ADDR_WIDTH-1:0];
            r_is_write <= w_rx_word[RW_BIT];
            r_load     <= 1'b1;
         end

         if (w_word_done) begin
            r_addr <= w_addr_nxt;
            r_load <= 1'b1;
            if (w_wr_en) begin
               r_wr_strobe <= 1'b1;
               r_wr_addr   <= r_addr;
            end
         end

         // CPHA=0 holds the preloaded MSB until the first sample of the word
         if ((r_state == DATA) && w_shift && (r_cpha || (r_bit_cnt != '0))) begin
            r_miso <= r_tx[REG_WIDTH-1];
            r_tx   <= {r_tx[REG_WIDTH-2:0], 1'b0};
         end

         if (r_load) begin
            r_load <= 1'b0;
            r_tx   <= r_cpha ? w_rd_word : {w_rd_word[REG_WIDTH-2:0], 1'b0};
            if (!r_cpha) r_miso <= w_rd_word[REG_WIDTH-1];
         end

         if (w_state_nxt == IDLE) begin
            r_miso <= 1'b0;
            r_load <= 1'b0;
         end
      end
   end

   assign spi_miso_o    = r_miso;
   assign spi_miso_oe_o = r_busy;
   assign busy_o        = r_busy;
   assign wr_strobe_o   = r_wr_strobe;
   assign wr_addr_o     = r_wr_addr;
   assign rw_regs_o     = r_rw_flat;

endmodule

// File: tb/tb_spi_reg_bank_burst.sv
// Directed testbench for spi_reg_bank_burst: bit-level SPI master in all four modes.
module tb_spi_reg_bank_burst;

   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpol_i;
   logic        cpha_i;
   logic        spi_cs_n_i;
   logic        spi_clk_i;
   logic        spi_mosi_i;
   logic        spi_miso_o;
   logic        spi_miso_oe_o;
   logic [63:0] ro_regs_i;
   logic [63:0] rw_regs_o;
   logic        wr_strobe_o;
   logic [3:0]  wr_addr_o;
   logic        busy_o;

   int          n_vec = 0;
   int          n_err = 0;
   int          strobe_cnt = 0;
   int          oe_mis = 0;
   logic [3:0]  last_wr_addr = 4'd0;

   logic [7:0]  tx_w [8];
   logic [7:0]  rx_w [8];
   logic [7:0]  exp_rw [8];
   logic        mid_busy;
   logic        mid_oe;

   spi_reg_bank_burst dut (
      .clk          (clk),
      .rst          (rst),
      .cpol_i       (cpol_i),
      .cpha_i       (cpha_i),
      .spi_cs_n_i   (spi_cs_n_i),
      .spi_clk_i    (spi_clk_i),
      .spi_mosi_i   (spi_mosi_i),
      .spi_miso_o   (spi_miso_o),
      .spi_miso_oe_o(spi_miso_oe_o),
      .ro_regs_i    (ro_regs_i),
      .rw_regs_o    (rw_regs_o),
      .wr_strobe_o  (wr_strobe_o),
      .wr_addr_o    (wr_addr_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   // Strobe counter and oe/busy consistency monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (wr_strobe_o === 1'b1) begin
         strobe_cnt++;
         last_wr_addr = wr_addr_o;
      end
      if (spi_miso_oe_o !== busy_o) oe_mis++;
   end

   initial begin
      #900us;
      $display("FAIL watchdog: simulation did not finish, required finish before 900us");
      $fatal(1, "watchdog");
   end

   task automatic half_bit();
      repeat (HALF) @(negedge clk);
   endtask

   task automatic set_mode(input logic [1:0] m);
      @(negedge clk);
      cpol_i    = m[1];
      cpha_i    = m[0];
      spi_clk_i = m[1];
      repeat (4) @(negedge clk);
   endtask

   task automatic spi_word(input logic [7:0] w, input int nbits, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         if (!cpha_i) begin
            spi_mosi_i = w[i];
            half_bit();
            spi_clk_i  = ~cpol_i;
            r[i]       = spi_miso_o;
            half_bit();
            spi_clk_i  = cpol_i;
         end else begin
            spi_clk_i  = ~cpol_i;
            spi_mosi_i = w[i];
            half_bit();
            spi_clk_i  = cpol_i;
            r[i]       = spi_miso_o;
            half_bit();
         end
      end
   endtask

   task automatic frame(input int n);
      logic [7:0] r;
      spi_cs_n_i = 1'b0;
      half_bit();
      mid_busy = busy_o;
      mid_oe   = spi_miso_oe_o;
      for (int k = 0; k < n; k++) begin
         spi_word(tx_w[k], 8, r);
         rx_w[k] = r;
      end
      half_bit();
      spi_cs_n_i = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   function automatic logic [63:0] exp_flat();
      logic [63:0] f;
      for (int k = 0; k < 8; k++) f[k*8 +: 8] = exp_rw[k];
      return f;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++; if (rw_regs_o !== 64'h0) begin n_err++; $display("FAIL reset_rw: got %h want 0", rw_regs_o); end
      n_vec++; if (spi_miso_o !== 1'b0) begin n_err++; $display("FAIL reset_miso: got %b want 0", spi_miso_o); end
      n_vec++; if (spi_miso_oe_o !== 1'b0) begin n_err++; $display("FAIL reset_oe: got %b want 0", spi_miso_oe_o); end
      n_vec++; if (wr_strobe_o !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %b want 0", wr_strobe_o); end
      n_vec++; if (wr_addr_o !== 4'd0) begin n_err++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr_o); end
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_mode0_write();
      int s0;
      set_mode(2'b00);
      s0 = strobe_cnt;
      tx_w[0] = 8'h83; tx_w[1] = 8'hA5;
      frame(2);
      exp_rw[3] = 8'hA5;
      n_vec++; if (mid_busy !== 1'b1) begin n_err++; $display("FAIL w0_mid_busy: got %b want 1", mid_busy); end
      n_vec++; if (rw_regs_o !== exp_flat()) begin n_err++; $display("FAIL w0_regs: got %h want %h", rw_regs_o, exp_flat()); end
      n_vec++; if (strobe_cnt - s0 !== 1) begin n_err++; $display("FAIL w0_strobes: got %0d want 1", strobe_cnt - s0); end
      n_vec++; if (last_wr_addr !== 4'd3) begin n_err++; $display("FAIL w0_wr_addr: got %0d want 3", last_wr_addr); end
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL w0_busy_end: got %b want 0", busy_o); end
   endtask

   task automatic test_read_modes();
      for (int m = 1; m < 4; m++) begin
         set_mode(2'(m));
         tx_w[0] = 8'h83; tx_w[1] = 8'h5A;
         frame(2);
         exp_rw[3] = 8'h5A;
         n_vec++; if (rw_regs_o !== exp_flat()) begin n_err++; $display("FAIL mode%0d_write: got %h want %h", m, rw_regs_o, exp_flat()); end
         tx_w[0] = 8'h03; tx_w[1] = 8'hC7;
         frame(2);
         n_vec++; if (rx_w[0] !== 8'h00) begin n_err++; $display("FAIL mode%0d_cmd_miso: got %h want 00", m, rx_w[0]); end
         n_vec++; if (rx_w[1] !== 8'h5A) begin n_err++; $display("FAIL mode%0d_read: got %h want 5a", m, rx_w[1]); end
         n_vec++; if (mid_oe !== 1'b1) begin n_err++; $display("FAIL mode%0d_oe_mid: got %b want 1", m, mid_oe); end
         n_vec++; if (spi_miso_oe_o !== 1'b0) begin n_err++; $display("FAIL mode%0d_oe_end: got %b want 0", m, spi_miso_oe_o); end
         n_vec++; if (rw_regs_o !== exp_flat()) begin n_err++; $display("FAIL mode%0d_read_nowrite: got %h want %h", m, rw_regs_o, exp_flat()); end
      end
   endtask

   task automatic test_burst_write();
      int s0;
      set_mode(2'b00);
      s0 = strobe_cnt;
      tx_w[0] = 8'h8E; tx_w[1] = 8'h11; tx_w[2] = 8'h22; tx_w[3] = 8'h33; tx_w[4] = 8'h44;
      frame(5);
      exp_rw[0] = 8'h33; exp_rw[1] = 8'h44;
      n_vec++; if (rw_regs_o !== exp_flat()) begin n_err++; $display("FAIL bw_regs: got %h want %h", rw_regs_o, exp_flat()); end
      n_vec++; if (strobe_cnt - s0 !== 2) begin n_err++; $display("FAIL bw_strobes: got %0d want 2", strobe_cnt - s0); end
      n_vec++; if (last_wr_addr !== 4'd1) begin n_err++; $display("FAIL bw_last_addr: got %0d want 1", last_wr_addr); end
   endtask

   task automatic test_burst_read();
      int s0;
      for (int k = 0; k < 8; k++) ro_regs_i[k*8 +: 8] = 8'hF0 + 8'(k);
      set_mode(2'b00);
      tx_w[0] = 8'h87; tx_w[1] = 8'hC3;
      frame(2);
      exp_rw[7] = 8'hC3;
      s0 = strobe_cnt;
      tx_w[0] = 8'h07; tx_w[1] = 8'hFF; tx_w[2] = 8'hFF; tx_w[3] = 8'hFF;
      frame(4);
      n_vec++; if (rx_w[1] !== 8'hC3) begin n_err++; $display("FAIL br_rw7: got %h want c3", rx_w[1]); end
      n_vec++; if (rx_w[2] !== 8'hF0) begin n_err++; $display("FAIL br_ro0: got %h want f0", rx_w[2]); end
      n_vec++; if (rx_w[3] !== 8'hF1) begin n_err++; $display("FAIL br_ro1: got %h want f1", rx_w[3]); end
      n_vec++; if (strobe_cnt - s0 !== 0) begin n_err++; $display("FAIL br_no_strobe: got %0d want 0", strobe_cnt - s0); end
      n_vec++; if (rw_regs_o !== exp_flat()) begin n_err++; $display("FAIL br_regs_kept: got %h want %h", rw_regs_o, exp_flat()); end
      set_mode(2'b11);
      tx_w[0] = 8'h0F; tx_w[1] = 8'h00; tx_w[2] = 8'h00;
      frame(3);
      n_vec++; if (rx_w[1] !== 8'hF7) begin n_err++; $display("FAIL br_ro7: got %h want f7", rx_w[1]); end
      n_vec++; if (rx_w[2] !== 8'h33) begin n_err++; $display("FAIL br_wrap_rw0: got %h want 33", rx_w[2]); end
   endtask

   task automatic test_abort();
      int         s0;
      logic [7:0] r;
      set_mode(2'b00);
      s0 = strobe_cnt;
      spi_cs_n_i = 1'b0;
      half_bit();
      spi_word(8'h82, 8, r);
      spi_word(8'hFF, 5, r);
      half_bit();
      spi_cs_n_i = 1'b1;
      repeat (8) @(negedge clk);
      n_vec++; if (rw_regs_o !== exp_flat()) begin n_err++; $display("FAIL abort_regs: got %h want %h", rw_regs_o, exp_flat()); end
      n_vec++; if (strobe_cnt - s0 !== 0) begin n_err++; $display("FAIL abort_strobe: got %0d want 0", strobe_cnt - s0); end
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy_o); end
      tx_w[0] = 8'h82; tx_w[1] = 8'h6C;
      frame(2);
      exp_rw[2] = 8'h6C;
      n_vec++; if (rw_regs_o !== exp_flat()) begin n_err++; $display("FAIL abort_next_regs: got %h want %h", rw_regs_o, exp_flat()); end
      n_vec++; if (strobe_cnt - s0 !== 1) begin n_err++; $display("FAIL abort_next_strobe: got %0d want 1", strobe_cnt - s0); end
      n_vec++; if (last_wr_addr !== 4'd2) begin n_err++; $display("FAIL abort_next_addr: got %0d want 2", last_wr_addr); end
   endtask

   task automatic test_rst_mid_burst();
      int         s0;
      logic [7:0] r;
      set_mode(2'b00);
      spi_cs_n_i = 1'b0;
      half_bit();
      spi_word(8'h80, 8, r);
      spi_word(8'h12, 8, r);
      spi_word(8'hFF, 4, r);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_vec++; if (rw_regs_o !== 64'h0) begin n_err++; $display("FAIL rst_mid_rw: got %h want 0", rw_regs_o); end
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy_o); end
      n_vec++; if (spi_miso_oe_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_oe: got %b want 0", spi_miso_oe_o); end
      n_vec++; if (spi_miso_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_miso: got %b want 0", spi_miso_o); end
      n_vec++; if (wr_addr_o !== 4'd0) begin n_err++; $display("FAIL rst_mid_wr_addr: got %0d want 0", wr_addr_o); end
      rst        = 1'b0;
      spi_cs_n_i = 1'b1;
      repeat (10) @(negedge clk);
      for (int k = 0; k < 8; k++) exp_rw[k] = 8'h00;
      s0 = strobe_cnt;
      tx_w[0] = 8'h80; tx_w[1] = 8'h9C;
      frame(2);
      exp_rw[0] = 8'h9C;
      n_vec++; if (rw_regs_o !== exp_flat()) begin n_err++; $display("FAIL rst_after_regs: got %h want %h", rw_regs_o, exp_flat()); end
      n_vec++; if (strobe_cnt - s0 !== 1) begin n_err++; $display("FAIL rst_after_strobe: got %0d want 1", strobe_cnt - s0); end
      n_vec++; if (last_wr_addr !== 4'd0) begin n_err++; $display("FAIL rst_after_addr: got %0d want 0", last_wr_addr); end
   endtask

   task automatic test_oe_tracks_busy();
      n_vec++; if (oe_mis !== 0) begin n_err++; $display("FAIL oe_vs_busy: got %0d differing cycles want 0", oe_mis); end
   endtask

   initial begin
      rst        = 1'b1;
      cpol_i     = 1'b0;
      cpha_i     = 1'b0;
      spi_cs_n_i = 1'b1;
      spi_clk_i  = 1'b0;
      spi_mosi_i = 1'b0;
      ro_regs_i  = 64'h0;
      for (int k = 0; k < 8; k++) exp_rw[k] = 8'h00;

      test_reset();
      test_mode0_write();
      test_read_modes();
      test_burst_write();
      test_burst_read();
      test_abort();
      test_rst_mid_burst();
      test_oe_tracks_busy();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
